rom_sample_reader: RTL and testbench

ROM_SAMPLE_READER -- requirements
Module: rom_sample_reader

---
 rtl/dds_pkg.sv | 14 +
 rtl/sample_fifo.sv | 69 ++++++
 rtl/rom_sample_reader.sv | 107 ++++++++++
 tb/tb_rom_sample_reader.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared DDS definitions: default ROM address/sample widths and the FIFO level width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dds_pkg;

  localparam int DDS_ADDR_W = 12;
  localparam int DDS_DATA_W = 12;

  // A level counter must represent 0..depth inclusive, hence one bit above clog2.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through sample FIFO with occupancy output.
// Latency: a write is visible on o_rd_dat/o_rd_vld the cycle after it is accepted.
// Backpressure: holds head data stable while i_rd_rdy=0; accepts a write when full only alongside a pop.
//
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_wr_vld, i_wr_dat  write strobe and data
//   o_rd_vld, o_rd_dat  head-of-queue valid and data (data reads 0 while empty)
//   i_rd_rdy            consumer accept
//   o_level             current occupancy, 0..DEPTH
module sample_fifo
  import dds_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int W     = DDS_DATA_W,
  localparam int LVL_W = level_w(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_vld,
  input  logic [W-1:0]     i_wr_dat,
  output logic             o_rd_vld,
  output logic [W-1:0]     o_rd_dat,
  input  logic             i_rd_rdy,
  output logic [LVL_W-1:0] o_level
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LVL_W'(DEPTH));
  // Read side ignores i_rd_rdy while empty, so an empty FIFO can never underflow.
  assign w_pop   = !w_empty && i_rd_rdy;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_push  = i_wr_vld && (!w_full || w_pop);

  // Pointers are PTR_W bits wide and DEPTH is a power of two, so they wrap on their own.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_level <= r_level + LVL_W'(1);
      else if (w_pop && !w_push) r_level <= r_level - LVL_W'(1);
    end
  end

  // Storage carries no reset; stale entries are never exposed because the output is gated by level.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_dat;
  end

  assign o_rd_vld = !w_empty;
  assign o_rd_dat = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level  = r_level;

endmodule

// File: rtl/rom_sample_reader.sv
// Phase-accumulator ROM reader: steps a phase by FTW, reads the ROM, queues samples in a FIFO.
// Latency: sample for an issued read appears on OUT_DATA ROM_LAT+1 cycles after the issue edge.
// Backpressure: reads issue only while FIFO level plus in-flight reads is below FIFO_DEPTH.
//
// Ports:
//   CLK, RESET          clock, async active-low reset
//   EN, SYNC, FTW       read enable, phase-clear pulse, phase step
//   ROM_ADDRESS, ROM_Q  registered ROM address out, ROM data in (ROM_LAT cycles behind the address)
//   OUT_DATA/VALID/READY  valid/ready sample output
//   LEVEL               FIFO occupancy
// Build option: define ROM_SAMPLE_READER_SIGNED_EN to convert offset-binary ROM data to two's complement.
module rom_sample_reader
  import dds_pkg::*;
#(
  parameter  int ADDR_W     = DDS_ADDR_W,
  parameter  int DATA_W     = DDS_DATA_W,
  parameter  int ROM_LAT    = 1,
  parameter  int FIFO_DEPTH = 4,
  localparam int LVL_W      = level_w(FIFO_DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN,
  input  logic              SYNC,
  input  logic [ADDR_W-1:0] FTW,
  output logic [ADDR_W-1:0] ROM_ADDRESS,
  input  logic [DATA_W-1:0] ROM_Q,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [LVL_W-1:0]  LEVEL
);

  logic [ADDR_W-1:0]  r_phase;
  logic [ADDR_W-1:0]  r_rom_addr;
  // r_addr_vld marks the read currently presented on ROM_ADDRESS; r_inflight then
  // follows it through the ROM pipeline so the last stage lines up with its ROM_Q.
  logic               r_addr_vld;
  logic [ROM_LAT-1:0] r_inflight;

  logic [31:0]        w_used;
  logic               w_issue;
  logic [ADDR_W-1:0]  w_issue_addr;
  logic               w_wr_vld;
  logic [DATA_W-1:0]  w_wr_dat;
  logic [LVL_W-1:0]   w_level;

  // Credits consumed = samples already queued plus every read not yet written.
  always_comb begin
    w_used = 32'(w_level) + {31'b0, r_addr_vld};
    for (int i = 0; i < ROM_LAT; i++) begin
      w_used = w_used + {31'b0, r_inflight[i]};
    end
  end

  assign w_issue      = EN && (w_used < 32'(FIFO_DEPTH));
  // SYNC zeroes the phase before it is used, so a coincident read goes to address 0.
  assign w_issue_addr = SYNC ? '0 : r_phase;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_phase    <= '0;
      r_rom_addr <= '0;
      r_addr_vld <= 1'b0;
      r_inflight <= '0;
    end else begin
      r_addr_vld    <= w_issue;
      r_inflight[0] <= r_addr_vld;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_inflight[i] <= r_inflight[i-1];
      end
      if (w_issue) begin
        r_rom_addr <= w_issue_addr;
        r_phase    <= w_issue_addr + FTW;
      end else if (SYNC) begin
        r_phase    <= '0;
      end
    end
  end

  assign w_wr_vld = r_inflight[ROM_LAT-1];

`ifdef ROM_SAMPLE_READER_SIGNED_EN
  // Flipping the MSB maps offset-binary onto two's complement.
  assign w_wr_dat = {~ROM_Q[DATA_W-1], ROM_Q[DATA_W-2:0]};
`else
  assign w_wr_dat = ROM_Q;
`endif

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .i_clk    (CLK),
    .i_rst_n  (RESET),
    .i_wr_vld (w_wr_vld),
    .i_wr_dat (w_wr_dat),
    .o_rd_vld (OUT_VALID),
    .o_rd_dat (OUT_DATA),
    .i_rd_rdy (OUT_READY),
    .o_level  (w_level)
  );

  assign ROM_ADDRESS = r_rom_addr;
  assign LEVEL       = w_level;

endmodule

// File: tb/tb_rom_sample_reader.sv
// Randomized scoreboard bench for rom_sample_reader with a queue-based reference model.
// Latency: n/a (testbench).
// Backpressure: drives OUT_READY randomly and in directed stall windows.
module tb_rom_sample_reader;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 12;
  localparam int ROM_LAT = 1;
  localparam int DEPTH   = 4;
  localparam int LVL_W   = $clog2(DEPTH) + 1;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              EN = 1'b0;
  logic              SYNC = 1'b0;
  logic [ADDR_W-1:0] FTW = '0;
  logic              OUT_READY = 1'b0;
  logic [ADDR_W-1:0] ROM_ADDRESS;
  logic [DATA_W-1:0] ROM_Q;
  logic [DATA_W-1:0] OUT_DATA;
  logic              OUT_VALID;
  logic [LVL_W-1:0]  LEVEL;

  rom_sample_reader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .ROM_LAT    (ROM_LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .EN          (EN),
    .SYNC        (SYNC),
    .FTW         (FTW),
    .ROM_ADDRESS (ROM_ADDRESS),
    .ROM_Q       (ROM_Q),
    .OUT_DATA    (OUT_DATA),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .LEVEL       (LEVEL)
  );

  always #5 CLK = ~CLK;

  // ROM holds its own address; data emerges ROM_LAT clocks after the address is presented.
  logic [DATA_W-1:0] rom_pipe [ROM_LAT];
  always @(posedge CLK) begin
    rom_pipe[0] <= ROM_ADDRESS;
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign ROM_Q = rom_pipe[ROM_LAT-1];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase value, write-time of each outstanding sample, expected data queue.
  int                edge_no = 0;
  logic [ADDR_W-1:0] m_phase = '0;
  int                m_wt[$];
  logic [DATA_W-1:0] sb_q[$];
  int                exp_level = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_sample(input logic [ADDR_W-1:0] a);
`ifdef ROM_SAMPLE_READER_SIGNED_EN
    return a ^ 12'h800;
`else
    return a;
`endif
  endfunction

  // One clock edge of the model. Outstanding reads (issued, not yet consumed) are the
  // credits in use; a sample becomes visible ROM_LAT+1 edges after its issue edge.
  task automatic model_edge();
    int used;
    logic [ADDR_W-1:0] a;
    used = m_wt.size();
    if (m_wt.size() > 0 && m_wt[0] < edge_no && OUT_READY) void'(m_wt.pop_front());
    if (EN && used < DEPTH) begin
      a = SYNC ? '0 : m_phase;
      m_wt.push_back(edge_no + ROM_LAT + 1);
      sb_q.push_back(exp_sample(a));
      m_phase = a + FTW;
    end else if (SYNC) begin
      m_phase = '0;
    end
    exp_level = 0;
    foreach (m_wt[i]) if (m_wt[i] <= edge_no) exp_level++;
    edge_no++;
  endtask

  task automatic step(input logic en, input logic sync, input logic [ADDR_W-1:0] ftw,
                      input logic rdy);
    @(posedge CLK);
    if (RESET) model_edge();
    #1;
    EN = en;
    SYNC = sync;
    FTW = ftw;
    OUT_READY = rdy;
  endtask

  // Monitor: compares occupancy/valid every cycle, and data on every DUT transfer.
  initial begin
    logic [DATA_W-1:0] e;
    forever begin
      @(negedge CLK);
      check("level", 32'(LEVEL), 32'(exp_level));
      check("valid", 32'(OUT_VALID), 32'(exp_level != 0));
      if (OUT_VALID && OUT_READY) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_out: got 0x%0h expected no sample at %0t", OUT_DATA, $time);
        end else begin
          e = sb_q.pop_front();
          check("data", 32'(OUT_DATA), 32'(e));
        end
      end
    end
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_addr", 32'(ROM_ADDRESS), 32'h0);
    check("rst_data", 32'(OUT_DATA), 32'h0);
    @(posedge CLK);
    #1 RESET = 1'b1;

    // Basic run, FTW=1: first issued address must be 0.
    step(1'b1, 1'b0, 12'd1, 1'b1);
    step(1'b1, 1'b0, 12'd1, 1'b1);
    @(negedge CLK);
    check("first_addr", 32'(ROM_ADDRESS), 32'h0);
    repeat (20) step(1'b1, 1'b0, 12'd1, 1'b1);

    // Wrap with a large step.
    repeat (8) step(1'b1, 1'b0, 12'hC00, 1'b1);

    // Backpressure: level must saturate at the FIFO depth.
    repeat (10) step(1'b1, 1'b0, 12'd1, 1'b0);
    @(negedge CLK);
    check("bp_level", 32'(LEVEL), 32'(DEPTH));
    repeat (10) step(1'b1, 1'b0, 12'd1, 1'b1);

    // SYNC with a non-zero phase.
    repeat (3) step(1'b1, 1'b0, 12'h123, 1'b1);
    step(1'b1, 1'b1, 12'h123, 1'b1);
    repeat (6) step(1'b1, 1'b0, 12'h123, 1'b1);

    // Fill partially with reads still in flight, then reset mid-operation.
    repeat (4) step(1'b1, 1'b0, 12'd7, 1'b0);
    @(posedge CLK);
    model_edge();
    #1;
    RESET = 1'b0;
    EN = 1'b0;
    SYNC = 1'b0;
    OUT_READY = 1'b1;
    m_wt.delete();
    sb_q.delete();
    m_phase = '0;
    exp_level = 0;
    @(negedge CLK);
    check("midrst_level", 32'(LEVEL), 32'h0);
    check("midrst_valid", 32'(OUT_VALID), 32'h0);
    check("midrst_addr", 32'(ROM_ADDRESS), 32'h0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    repeat (12) step(1'b1, 1'b0, 12'd5, 1'b1);

    // Randomized traffic.
    repeat (1500) begin
      step($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0, 12'($urandom),
           $urandom_range(0, 9) < 6);
    end

    // Drain and confirm every expected sample arrived.
    repeat (20) step(1'b0, 1'b0, 12'd0, 1'b1);
    @(negedge CLK);
    check("drain_left", 32'(sb_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
